// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write scoreboard between ID and RF write-back.
// Produces the ID stall and registered EXE forwarding selects.
module hazard_scoreboard #(
  parameter int REG_FILE_ADDR_LEN = 5,
  parameter int PIPE_DEPTH        = 3,
  parameter int ALU_READY         = 2,
  parameter int LOAD_READY        = 3,
  parameter int STALL_CNT_LEN     = 16,
  localparam int SEL_W            = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         forward_EN,
  input  logic                         issue_valid,
  input  logic [REG_FILE_ADDR_LEN-1:0] src1_ID,
  input  logic                         src1_used,
  input  logic [REG_FILE_ADDR_LEN-1:0] src2_ID,
  input  logic                         src2_used,
  input  logic [REG_FILE_ADDR_LEN-1:0] dest_ID,
  input  logic                         WB_EN_ID,
  input  logic                         MEM_R_EN_ID,
  output logic                         hazard_detected,
  output logic [SEL_W-1:0]             val1_sel,
  output logic [SEL_W-1:0]             val2_sel,
  output logic [STALL_CNT_LEN-1:0]     stall_cycles
);

  logic [PIPE_DEPTH:1]          vld_q;
  logic [PIPE_DEPTH:1]          ld_q;
  logic [REG_FILE_ADDR_LEN-1:0] dst_q [PIPE_DEPTH:1];

  logic [SEL_W-1:0]         sel1_q, sel2_q;
  logic [STALL_CNT_LEN-1:0] stall_q;

  logic [REG_FILE_ADDR_LEN-1:0] src_c  [2];
  logic [1:0]                   used_c;
  logic [1:0]                   haz_c;
  logic [SEL_W-1:0]             sel_c  [2];

  assign src_c[0]  = src1_ID;
  assign src_c[1]  = src2_ID;
  assign used_c[0] = src1_used;
  assign used_c[1] = src2_used;

  // Youngest-match lookup per source; decide forward slot or stall.
  always_comb begin : lookup
    int   hk;
    logic hit;
    logic hld;
    haz_c    = '0;
    sel_c[0] = '0;
    sel_c[1] = '0;
    for (int s = 0; s < 2; s++) begin
      hit = 1'b0;
      hk  = 0;
      hld = 1'b0;
      // Scan oldest to youngest so the lowest slot wins.
      for (int k = PIPE_DEPTH; k >= 1; k--) begin
        if (vld_q[k] && (dst_q[k] == src_c[s])) begin
          hit = 1'b1;
          hk  = k;
          hld = ld_q[k];
        end
      end
      if (issue_valid && used_c[s] && (src_c[s] != '0) &&
          hit && (hk != PIPE_DEPTH)) begin
        if (forward_EN &&
            ((hk + 1) >= (hld ? LOAD_READY : ALU_READY)))
          sel_c[s] = SEL_W'(hk + 1);
        else
          haz_c[s] = 1'b1;
      end
    end
  end

  assign hazard_detected = (|haz_c) & ~rst;

  // Shift scoreboard, register selects, count stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      ld_q    <= '0;
      sel1_q  <= '0;
      sel2_q  <= '0;
      stall_q <= '0;
      for (int k = 1; k <= PIPE_DEPTH; k++)
        dst_q[k] <= '0;
    end else begin
      vld_q[1] <= issue_valid & WB_EN_ID &
                  (dest_ID != '0) & ~hazard_detected;
      dst_q[1] <= dest_ID;
      ld_q[1]  <= MEM_R_EN_ID;
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        vld_q[k] <= vld_q[k-1];
        dst_q[k] <= dst_q[k-1];
        ld_q[k]  <= ld_q[k-1];
      end
      if (issue_valid && !hazard_detected) begin
        sel1_q <= sel_c[0];
        sel2_q <= sel_c[1];
      end else begin
        sel1_q <= '0;
        sel2_q <= '0;
      end
      if (hazard_detected && !(&stall_q))
        stall_q <= stall_q + 1'b1;
    end
  end

  assign val1_sel     = sel1_q;
  assign val2_sel     = sel2_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with an expected-select queue.
// Hazard checked same cycle, selects checked one cycle later.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       forward_EN;
  logic       issue_valid;
  logic [4:0] src1_ID, src2_ID, dest_ID;
  logic       src1_used, src2_used;
  logic       WB_EN_ID, MEM_R_EN_ID;
  logic       hazard_detected;
  logic [1:0] val1_sel, val2_sel;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_stall = 0;
  logic [3:0] sel_q [$];

  hazard_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .forward_EN      (forward_EN),
    .issue_valid     (issue_valid),
    .src1_ID         (src1_ID),
    .src1_used       (src1_used),
    .src2_ID         (src2_ID),
    .src2_used       (src2_used),
    .dest_ID         (dest_ID),
    .WB_EN_ID        (WB_EN_ID),
    .MEM_R_EN_ID     (MEM_R_EN_ID),
    .hazard_detected (hazard_detected),
    .val1_sel        (val1_sel),
    .val2_sel        (val2_sel),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic set(input logic iv, input logic [4:0] s1,
                     input logic u1, input logic [4:0] s2,
                     input logic u2, input logic [4:0] d,
                     input logic wb, input logic ld);
    issue_valid = iv;
    src1_ID     = s1;
    src1_used   = u1;
    src2_ID     = s2;
    src2_used   = u2;
    dest_ID     = d;
    WB_EN_ID    = wb;
    MEM_R_EN_ID = ld;
  endtask

  task automatic idle();
    set(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: push expected selects, check hazard, then pop and check.
  task automatic tick(input string tag, input logic eh,
                      input logic [1:0] e1, input logic [1:0] e2);
    logic [3:0] e;
    sel_q.push_back({e1, e2});
    #2;
    chk({tag, "_haz"}, {15'd0, hazard_detected}, {15'd0, eh});
    if (rst) exp_stall = 0;
    else if (eh) exp_stall++;
    @(posedge clk);
    #1;
    if (sel_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = sel_q.pop_front();
      chk({tag, "_sel1"}, {14'd0, val1_sel}, {14'd0, e[3:2]});
      chk({tag, "_sel2"}, {14'd0, val2_sel}, {14'd0, e[1:0]});
    end
  endtask

  task automatic flush();
    idle();
    repeat (3) tick("idle", 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    rst        = 1'b1;
    forward_EN = 1'b1;
    idle();
    @(posedge clk);
    #1;
    tick("rst", 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    chk("rst_stall", stall_cycles, 16'(exp_stall));
    flush();

    // ALU result forwarded from slot 2
    set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick("alu_prod", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0);
    tick("alu_cons", 1'b0, 2'd2, 2'd0);
    flush();
    chk("alu_stall", stall_cycles, 16'(exp_stall));

    // load-use: one stall then forward from slot 3
    set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick("ld_prod", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0);
    tick("ld_stall", 1'b1, 2'd0, 2'd0);
    tick("ld_cons", 1'b0, 2'd0, 2'd3);
    flush();
    chk("ld_stall_cnt", stall_cycles, 16'(exp_stall));

    // shadowing: youngest r6 writer wins
    set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    tick("sh_w0", 1'b0, 2'd0, 2'd0);
    tick("sh_w1", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd11, 1'b1, 1'b0);
    tick("sh_cons", 1'b0, 2'd2, 2'd2);
    flush();

    // src2 match ignored when src2 is unused
    set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick("nu_prod", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd12, 1'b1, 5'd7, 1'b0, 5'd13, 1'b1, 1'b0);
    tick("nu_cons", 1'b0, 2'd0, 2'd0);
    flush();

    // stall-only mode: two stalls then RF read
    forward_EN = 1'b0;
    set(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    tick("so_prod", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd3, 1'b1, 5'd14, 1'b1, 5'd15, 1'b1, 1'b0);
    tick("so_st1", 1'b1, 2'd0, 2'd0);
    tick("so_st2", 1'b1, 2'd0, 2'd0);
    tick("so_cons", 1'b0, 2'd0, 2'd0);
    flush();
    chk("so_stall_cnt", stall_cycles, 16'(exp_stall));

    // r0 destination never tracked, r0 source never checked
    set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick("r0_prod", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd16, 1'b1, 1'b0);
    tick("r0_cons", 1'b0, 2'd0, 2'd0);
    flush();
    forward_EN = 1'b1;

    // reset during a load-use stall
    set(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
    tick("rs_prod", 1'b0, 2'd0, 2'd0);
    set(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 1'b0);
    tick("rs_stall", 1'b1, 2'd0, 2'd0);
    chk("rs_pre_cnt", stall_cycles, 16'(exp_stall));
    rst = 1'b1;
    tick("rs_rst", 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
    chk("rs_cnt", stall_cycles, 16'(exp_stall));
    tick("rs_reissue", 1'b0, 2'd0, 2'd0);
    flush();
    chk("end_cnt", stall_cycles, 16'(exp_stall));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the ID-stage hazard detection unit. It tracks every in-flight register write between ID and register-file write-back in a shift-register scoreboard. From that it produces the stall signal and registered forwarding selects (`val1_sel`/`val2_sel`) for the EXE stage. Depth, forwarding readiness and register-address width are parameters, and a saturating stall counter is kept for performance analysis.

## Interface
Parameters:
- `REG_FILE_ADDR_LEN`, 5, register address width
- `PIPE_DEPTH`, 3, pipeline registers between ID and RF write (slot 1 = ID/EXE … slot `PIPE_DEPTH` = MEM/WB)
- `ALU_READY`, 2, first slot whose non-load result is forwardable
- `LOAD_READY`, 3, first slot whose load result is forwardable; legal range `1 ≤ ALU_READY ≤ LOAD_READY ≤ PIPE_DEPTH`
- `STALL_CNT_LEN`, 16, stall counter width
- localparam `SEL_W` = `$clog2(PIPE_DEPTH+1)`

Ports:
- `clk`  in  1  clock, one clock domain
- `rst`  in  1  synchronous, active-high reset
- `forward_EN`  in  1  1 = forwarding mode, 0 = stall-only mode
- `issue_valid`  in  1  ID holds a valid, non-flushed instruction
- `src1_ID`  in  `REG_FILE_ADDR_LEN`  first source register
- `src1_used`  in  1  src1 is read (0 for JMP)
- `src2_ID`  in  `REG_FILE_ADDR_LEN`  second source / store-data register
- `src2_used`  in  1  `~is_imm | ST_or_BNE`
- `dest_ID`  in  `REG_FILE_ADDR_LEN`  destination register
- `WB_EN_ID`  in  1  instruction writes the RF
- `MEM_R_EN_ID`  in  1  instruction is a load
- `hazard_detected`  out  1  stall ID/IF this cycle; inject bubble
- `val1_sel`  out  `SEL_W`  registered forward source for src1 in EXE; 0 = RF, k = slot k
- `val2_sel`  out  `SEL_W`  same for src2 (also used as store-value select)
- `stall_cycles`  out  `STALL_CNT_LEN`  saturating count of stall cycles

## Operation
- Scoreboard: `PIPE_DEPTH` slots, each holding {valid, dest, is_load}.
- Slots shift every cycle: slot k+1 ← slot k. Slot `PIPE_DEPTH` retires.
- Slot 1 load rule:
  - Slot 1 ← {`issue_valid & WB_EN_ID & (dest_ID≠0) & !hazard_detected`, `dest_ID`, `MEM_R_EN_ID`}.
  - On stall, slot 1 gets a bubble (valid=0).
- Per-source check, applied only when `issue_valid` and srcN_used are both set and srcN≠0:
  - Find the youngest (lowest k) valid slot whose dest = srcN; older matches are shadowed.
  - No match → no hazard for that source, sel = 0.
  - Match at k = `PIPE_DEPTH` → RF is written this cycle (write-before-read) → no hazard, sel = 0.
  - `forward_EN=1`, k<`PIPE_DEPTH`: ready = `LOAD_READY` if is_load else `ALU_READY`. If k+1 ≥ ready → no hazard, sel = k+1. Otherwise hazard.
  - `forward_EN=0`, k<`PIPE_DEPTH` → hazard.
- `hazard_detected` = OR of both source hazards. It is combinational from the slots and the ID inputs, and is forced to 0 while `rst`=1.
- `val1_sel`/`val2_sel` are registered at each clock edge:
  - Loaded with the computed sel when `!hazard_detected & issue_valid`.
  - Otherwise 0 (bubble).
- `stall_cycles` increments on every clock edge with `hazard_detected`=1 and saturates at all-ones.
- Register 0 never creates or resolves a hazard.

## Timing
- Reset (synchronous, priority over everything): all slots invalid, `val1_sel`=`val2_sel`=0, `stall_cycles`=0, `hazard_detected`=0. Reset mid-stall drops the stall on the next cycle.
- `hazard_detected` has zero latency (same cycle as the ID inputs). Sels appear one cycle later, aligned with the instruction in EXE.
- Load-use with default parameters: exactly 1 stall cycle, then sel = 3.
- Stall-only mode with default parameters: a dependent instruction immediately after its producer stalls 2 cycles, then reads the RF (sel 0).
- Stall and issue in the same cycle: the bubble enters slot 1 and the ID instruction is re-evaluated next cycle against the shifted slots.

## Test plan
- `forward_EN`=1: ADD r3 issued at t; at t+1 ADD with src1=r3 → `hazard_detected`=0 at t+1, `val1_sel`=2 at t+2.
- LD r4 at t; ADD src2=r4 (src2_used=1) at t+1 → hazard=1 at t+1, hazard=0 at t+2, `val2_sel`=3 at t+3, `stall_cycles`=1.
- `forward_EN`=0: ADD r3 at t; consumer src1=r3 → hazard=1 at t+1 and t+2, 0 at t+3, `val1_sel`=0 at t+4, `stall_cycles`=2.
- Shadowing and r0:
  - Writes to r6 at t and t+1; consumer of r6 at t+2 → `val1_sel`=2 (youngest match), no hazard.
  - Any instruction with dest=r0 → never a hazard.
- src2=r7 matching slot 1, src2_used=0, src1 unrelated → hazard=0, `val2_sel`=0.
- Reset: `rst`=1 during a load-use stall → next cycle hazard=0, sels=0, `stall_cycles`=0. The same consumer re-issued afterwards finds an empty scoreboard → hazard=0.
